// File: rtl/sp_bram_arbiter.sv
// Two-requester arbiter for one scratchpad BRAM port. Round-robin arbitration with burst locking
// and a MAX_BURST cap; read data is steered back to its issuer through a latency-matched tag pipe.
module sp_bram_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 64,
  parameter int RD_LAT    = 1,
  parameter int MAX_BURST = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_wen,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic              m0_last,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_wen,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic              m1_last,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [ADDR_W-1:0] bram_addr,
  output logic              bram_wen,
  output logic [DATA_W-1:0] bram_wdata,
  input  logic [DATA_W-1:0] bram_rdata
);

  localparam int CNT_W = $clog2(MAX_BURST);

  typedef enum logic [1:0] {IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2} state_t;

  state_t              state_q, state_d;
  logic                rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]    burst_cnt_q, burst_cnt_d;
  logic [RD_LAT-1:0]   tag_vld_q, tag_vld_d;
  logic [RD_LAT-1:0]   tag_id_q, tag_id_d;
  logic [DATA_W-1:0]   rdata0_q, rdata0_d;
  logic [DATA_W-1:0]   rdata1_q, rdata1_d;
  logic                gnt_any, gnt_id, gnt_ok;
  logic                own_id, own_req, own_last, sel_wen;
  logic                rvalid0, rvalid1;

  // Arbitration state machine: picks the granted requester and tracks ownership.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    burst_cnt_d = burst_cnt_q;
    gnt_any     = 1'b0;
    gnt_id      = 1'b0;
    own_id      = (state_q == OWN1);
    own_req     = own_id ? m1_req : m0_req;
    own_last    = own_id ? m1_last : m0_last;
    case (state_q)
      IDLE: begin
        if (m0_req || m1_req) begin
          gnt_any = 1'b1;
          gnt_id  = (m0_req && m1_req) ? rr_ptr_q : m1_req;
          if (gnt_id ? m1_last : m0_last) begin
            rr_ptr_d = ~gnt_id;
          end else begin
            state_d     = gnt_id ? OWN1 : OWN0;
            burst_cnt_d = CNT_W'(1);
          end
        end else begin
          state_d = IDLE;
        end
      end
      OWN0, OWN1: begin
        // A dropped request ends the burst just like last does, minus the grant.
        if (own_req) begin
          gnt_any     = 1'b1;
          gnt_id      = own_id;
          burst_cnt_d = burst_cnt_q + CNT_W'(1);
          if (own_last || (burst_cnt_q == CNT_W'(MAX_BURST - 1))) begin
            state_d     = IDLE;
            rr_ptr_d    = ~own_id;
            burst_cnt_d = CNT_W'(0);
          end else begin
            state_d = state_q;
          end
        end else begin
          state_d     = IDLE;
          rr_ptr_d    = ~own_id;
          burst_cnt_d = CNT_W'(0);
        end
      end
      default: begin
        state_d     = IDLE;
        rr_ptr_d    = 1'b0;
        burst_cnt_d = CNT_W'(0);
      end
    endcase
  end

  // Grant steering, BRAM mux, read tag pipe and read-data return.
  always_comb begin
    gnt_ok  = gnt_any & ~rst;
    sel_wen = gnt_id ? m1_wen : m0_wen;
    m0_gnt  = gnt_ok & ~gnt_id;
    m1_gnt  = gnt_ok & gnt_id;
    if (gnt_ok) begin
      bram_addr  = gnt_id ? m1_addr : m0_addr;
      bram_wdata = gnt_id ? m1_wdata : m0_wdata;
      bram_wen   = sel_wen;
    end else begin
      bram_addr  = {ADDR_W{1'b0}};
      bram_wdata = {DATA_W{1'b0}};
      bram_wen   = 1'b0;
    end
    tag_vld_d    = {RD_LAT{1'b0}};
    tag_id_d     = {RD_LAT{1'b0}};
    tag_vld_d[0] = gnt_ok & ~sel_wen;
    tag_id_d[0]  = gnt_id;
    for (int i = 1; i < RD_LAT; i++) begin
      tag_vld_d[i] = tag_vld_q[i-1];
      tag_id_d[i]  = tag_id_q[i-1];
    end
    rvalid0   = ~rst & tag_vld_q[RD_LAT-1] & ~tag_id_q[RD_LAT-1];
    rvalid1   = ~rst & tag_vld_q[RD_LAT-1] & tag_id_q[RD_LAT-1];
    m0_rvalid = rvalid0;
    m1_rvalid = rvalid1;
    m0_rdata  = rvalid0 ? bram_rdata : rdata0_q;
    m1_rdata  = rvalid1 ? bram_rdata : rdata1_q;
    rdata0_d  = m0_rdata;
    rdata1_d  = m1_rdata;
  end

  // State, tag pipe and held read data registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= 1'b0;
      burst_cnt_q <= CNT_W'(0);
      tag_vld_q   <= {RD_LAT{1'b0}};
      tag_id_q    <= {RD_LAT{1'b0}};
      rdata0_q    <= {DATA_W{1'b0}};
      rdata1_q    <= {DATA_W{1'b0}};
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      burst_cnt_q <= burst_cnt_d;
      tag_vld_q   <= tag_vld_d;
      tag_id_q    <= tag_id_d;
      rdata0_q    <= rdata0_d;
      rdata1_q    <= rdata1_d;
    end
  end

endmodule

// File: tb/tb_sp_bram_arbiter.sv
// Bench for sp_bram_arbiter: requester queues drive the DUT, a transaction-level arbitration and
// read-return model predicts every output each cycle.
module tb_sp_bram_arbiter;
  localparam int AW = 32;
  localparam int DW = 64;
  localparam int RL = 2;
  localparam int MB = 16;
  localparam int VW = 229;
  localparam int B_G0 = 228;
  localparam int B_G1 = 227;
  localparam int B_RV0 = 226;
  localparam int B_RV1 = 225;
  localparam int B_WEN = 224;

  logic clk = 1'b0;
  logic rst;
  logic m0_req, m0_wen, m0_last, m0_gnt, m0_rvalid;
  logic m1_req, m1_wen, m1_last, m1_gnt, m1_rvalid;
  logic [AW-1:0] m0_addr, m1_addr, bram_addr;
  logic [DW-1:0] m0_wdata, m1_wdata, m0_rdata, m1_rdata, bram_wdata, bram_rdata;
  logic bram_wen;

  always #5 clk = ~clk;

  sp_bram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(RL), .MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_wen(m0_wen), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_last(m0_last),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_wen(m1_wen), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_last(m1_last),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .bram_addr(bram_addr), .bram_wen(bram_wen), .bram_wdata(bram_wdata), .bram_rdata(bram_rdata)
  );

  // BRAM with RL cycles of read latency
  logic [DW-1:0] mem [0:255];
  logic [DW-1:0] rd_pipe [0:RL-1];
  always @(posedge clk) begin
    if (bram_wen) mem[bram_addr[10:3]] <= bram_wdata;
    rd_pipe[0] <= mem[bram_addr[10:3]];
    for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign bram_rdata = rd_pipe[RL-1];

  typedef struct packed {
    logic          wen;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          last;
  } acc_t;
  typedef struct {
    int            due;
    int            id;
    logic [DW-1:0] data;
  } rd_t;

  acc_t q0[$];
  acc_t q1[$];
  rd_t  rq[$];
  logic hold0, hold1;
  logic [DW-1:0] shadow [0:255];
  logic [DW-1:0] exp_rd0, exp_rd1;
  int own, cnt, rr, cyc;
  int n_vec, n_bad;

  function automatic acc_t mk(input logic w, input logic [AW-1:0] ad, input logic [DW-1:0] d,
                              input logic l);
    acc_t r;
    r.wen = w; r.addr = ad; r.data = d; r.last = l;
    return r;
  endfunction

  function automatic acc_t rnd_acc();
    acc_t r;
    r.wen  = 1'($urandom);
    r.addr = {21'd0, 8'($urandom), 3'd0};
    r.data = {$urandom, $urandom};
    r.last = ($urandom_range(0, 9) < 3);
    return r;
  endfunction

  // One clock: drive queue heads, predict outputs, sample at negedge, then advance the model.
  task automatic cycle(output logic [VW-1:0] obs_v, output logic [VW-1:0] exp_v);
    int g;
    acc_t a;
    logic ev0, ev1, e_wen;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wd, ed0, ed1;
    a = rnd_acc();
    if (q0.size() > 0) a = q0[0];
    m0_req = (q0.size() > 0) && !hold0;
    m0_wen = a.wen; m0_addr = a.addr; m0_wdata = a.data; m0_last = a.last;
    a = rnd_acc();
    if (q1.size() > 0) a = q1[0];
    m1_req = (q1.size() > 0) && !hold1;
    m1_wen = a.wen; m1_addr = a.addr; m1_wdata = a.data; m1_last = a.last;
    g = -1;
    if (!rst) begin
      if (own < 0) begin
        if (m0_req && m1_req) g = rr;
        else if (m0_req) g = 0;
        else if (m1_req) g = 1;
      end else if ((own == 0 && m0_req) || (own == 1 && m1_req)) begin
        g = own;
      end
    end
    e_wen = 1'b0; e_addr = '0; e_wd = '0;
    if (g >= 0) begin
      a = (g == 0) ? q0[0] : q1[0];
      e_wen = a.wen; e_addr = a.addr; e_wd = a.data;
    end
    ev0 = 1'b0; ev1 = 1'b0; ed0 = exp_rd0; ed1 = exp_rd1;
    if (!rst && rq.size() > 0 && rq[0].due == cyc) begin
      if (rq[0].id == 0) begin ev0 = 1'b1; ed0 = rq[0].data; end
      else begin ev1 = 1'b1; ed1 = rq[0].data; end
    end
    exp_v = {g == 0, g == 1, ev0, ev1, e_wen, e_addr, e_wd, ed0, ed1};
    @(negedge clk);
    obs_v = {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, bram_wen, bram_addr, bram_wdata, m0_rdata, m1_rdata};
    @(posedge clk);
    if (rst) begin
      own = -1; cnt = 0; rr = 0; rq.delete(); exp_rd0 = '0; exp_rd1 = '0;
    end else begin
      if (ev0 || ev1) begin
        exp_rd0 = ed0; exp_rd1 = ed1;
        void'(rq.pop_front());
      end
      if (g >= 0) begin
        if (g == 0) a = q0.pop_front(); else a = q1.pop_front();
        if (a.wen) shadow[a.addr[10:3]] = a.data;
        else rq.push_back('{due: cyc + RL, id: g, data: shadow[a.addr[10:3]]});
        if (own < 0) begin
          if (a.last) rr = 1 - g;
          else begin own = g; cnt = 1; end
        end else begin
          cnt++;
          if (a.last || cnt == MB) begin own = -1; rr = 1 - g; end
        end
      end else if (own >= 0) begin
        rr = 1 - own; own = -1;
      end
    end
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    logic [VW-1:0] o, e;
    rst = 1'b1;
    q0.push_back(mk(1'b0, 32'h8, 64'h1, 1'b1));
    q1.push_back(mk(1'b1, 32'h10, 64'h2, 1'b1));
    for (int i = 0; i < 2; i++) begin
      cycle(o, e);
      n_vec++; if (o !== e) begin n_bad++; $display("FAIL reset_hold cyc=%0d got=%h want=%h", cyc, o, e); end
      n_vec++; if (o[B_G0] !== 1'b0 || o[B_G1] !== 1'b0 || o[B_WEN] !== 1'b0)
        begin n_bad++; $display("FAIL reset_gnt got=%b%b%b want=000", o[B_G0], o[B_G1], o[B_WEN]); end
    end
    rst = 1'b0; q0.delete(); q1.delete();
    for (int i = 0; i < 3; i++) begin
      cycle(o, e);
      n_vec++; if (o !== e) begin n_bad++; $display("FAIL reset_idle cyc=%0d got=%h want=%h", cyc, o, e); end
    end
  endtask

  task automatic test_single_reads();
    logic [VW-1:0] o, e;
    int ng, nrv, nrv1;
    ng = 0; nrv = 0; nrv1 = 0;
    for (int i = 0; i < 3; i++) begin mem[i] = 64'hA0 + 64'(i); shadow[i] = 64'hA0 + 64'(i); end
    q0.push_back(mk(1'b0, 32'h00, 64'h0, 1'b0));
    q0.push_back(mk(1'b0, 32'h08, 64'h0, 1'b0));
    q0.push_back(mk(1'b0, 32'h10, 64'h0, 1'b1));
    for (int i = 0; i < 8; i++) begin
      cycle(o, e);
      n_vec++; if (o !== e) begin n_bad++; $display("FAIL single cyc=%0d got=%h want=%h", cyc, o, e); end
      ng += int'(o[B_G0]); nrv += int'(o[B_RV0]); nrv1 += int'(o[B_RV1]);
    end
    n_vec++; if (ng !== 3) begin n_bad++; $display("FAIL single_gnts got=%0d want=3", ng); end
    n_vec++; if (nrv !== 3 || nrv1 !== 0)
      begin n_bad++; $display("FAIL single_rvalid got=%0d/%0d want=3/0", nrv, nrv1); end
  endtask

  task automatic test_contention();
    logic [VW-1:0] o, e;
    logic [1:0] want;
    rst = 1'b1;
    cycle(o, e);
    n_vec++; if (o !== e) begin n_bad++; $display("FAIL cont_rst cyc=%0d got=%h want=%h", cyc, o, e); end
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      q0.push_back(mk(1'b0, AW'(32'h200 + 8 * k), 64'h0, k == 1));
      q1.push_back(mk(1'b0, AW'(32'h300 + 8 * k), 64'h0, k == 1));
    end
    for (int k = 0; k < 8; k++) begin
      cycle(o, e);
      n_vec++; if (o !== e) begin n_bad++; $display("FAIL cont cyc=%0d got=%h want=%h", cyc, o, e); end
      if (k < 4) begin
        want = (k < 2) ? 2'b10 : 2'b01;
        n_vec++; if (o[B_G0:B_G1] !== want)
          begin n_bad++; $display("FAIL cont_order k=%0d got=%b want=%b", k, o[B_G0:B_G1], want); end
      end
    end
  endtask

  task automatic test_max_burst();
    logic [VW-1:0] o, e;
    int n0_first, n0, n1;
    logic seen1;
    n0_first = 0; n0 = 0; n1 = 0; seen1 = 1'b0;
    for (int k = 0; k < 20; k++) q0.push_back(mk(1'b0, AW'(8 * k), 64'h0, 1'b0));
    for (int k = 0; k < 3; k++) q1.push_back(mk(1'b0, AW'(32'h400 + 8 * k), 64'h0, k == 2));
    hold1 = 1'b1;
    for (int k = 0; k < 40; k++) begin
      cycle(o, e);
      hold1 = 1'b0;
      n_vec++; if (o !== e) begin n_bad++; $display("FAIL burst cyc=%0d got=%h want=%h", cyc, o, e); end
      if (o[B_G1]) seen1 = 1'b1;
      if (o[B_G0] && !seen1) n0_first++;
      n0 += int'(o[B_G0]); n1 += int'(o[B_G1]);
    end
    n_vec++; if (n0_first !== MB) begin n_bad++; $display("FAIL burst_cap got=%0d want=%0d", n0_first, MB); end
    n_vec++; if (n0 !== 20 || n1 !== 3)
      begin n_bad++; $display("FAIL burst_totals got=%0d/%0d want=20/3", n0, n1); end
  endtask

  task automatic test_interleave();
    logic [VW-1:0] o, e;
    mem[8] = 64'h11; shadow[8] = 64'h11;
    mem[9] = 64'h22; shadow[9] = 64'h22;
    q0.push_back(mk(1'b0, 32'h40, 64'h0, 1'b1));
    q1.push_back(mk(1'b0, 32'h48, 64'h0, 1'b1));
    hold1 = 1'b1;
    for (int k = 0; k < 6; k++) begin
      cycle(o, e);
      hold1 = 1'b0;
      n_vec++; if (o !== e) begin n_bad++; $display("FAIL ilv cyc=%0d got=%h want=%h", cyc, o, e); end
      if (k == 2) begin
        n_vec++; if (o[B_RV0] !== 1'b1 || o[127:64] !== 64'h11)
          begin n_bad++; $display("FAIL ilv_m0 got=%b/%h want=1/11", o[B_RV0], o[127:64]); end
      end
      if (k == 3) begin
        n_vec++; if (o[B_RV1] !== 1'b1 || o[63:0] !== 64'h22)
          begin n_bad++; $display("FAIL ilv_m1 got=%b/%h want=1/22", o[B_RV1], o[63:0]); end
      end
    end
  endtask

  task automatic test_write_readback();
    logic [VW-1:0] o, e;
    int nw, nrv;
    logic [DW-1:0] got;
    nw = 0; nrv = 0; got = '0;
    q1.push_back(mk(1'b1, 32'h100, 64'hDEADBEEF_CAFEF00D, 1'b1));
    q1.push_back(mk(1'b0, 32'h100, 64'h0, 1'b1));
    for (int k = 0; k < 6; k++) begin
      cycle(o, e);
      n_vec++; if (o !== e) begin n_bad++; $display("FAIL wrrd cyc=%0d got=%h want=%h", cyc, o, e); end
      nw += int'(o[B_WEN]); nrv += int'(o[B_RV1]);
      if (o[B_RV1]) got = o[63:0];
    end
    n_vec++; if (nw !== 1 || nrv !== 1)
      begin n_bad++; $display("FAIL wrrd_counts got=%0d/%0d want=1/1", nw, nrv); end
    n_vec++; if (got !== 64'hDEADBEEF_CAFEF00D)
      begin n_bad++; $display("FAIL wrrd_data got=%h want=deadbeefcafef00d", got); end
  endtask

  task automatic test_reset_midburst();
    logic [VW-1:0] o, e;
    int nrv;
    nrv = 0;
    for (int k = 0; k < 6; k++) q0.push_back(mk(1'b0, AW'(8 * k), 64'h0, 1'b0));
    for (int k = 0; k < 2; k++) begin
      cycle(o, e);
      n_vec++; if (o !== e) begin n_bad++; $display("FAIL mid_pre cyc=%0d got=%h want=%h", cyc, o, e); end
    end
    rst = 1'b1;
    cycle(o, e);
    n_vec++; if (o !== e) begin n_bad++; $display("FAIL mid_rst cyc=%0d got=%h want=%h", cyc, o, e); end
    rst = 1'b0; q0.delete();
    for (int k = 0; k < 4; k++) begin
      cycle(o, e);
      n_vec++; if (o !== e) begin n_bad++; $display("FAIL mid_post cyc=%0d got=%h want=%h", cyc, o, e); end
      nrv += int'(o[B_RV0]);
    end
    n_vec++; if (nrv !== 0) begin n_bad++; $display("FAIL mid_discard got=%0d want=0", nrv); end
    q0.push_back(mk(1'b0, 32'h18, 64'h0, 1'b1));
    q1.push_back(mk(1'b0, 32'h20, 64'h0, 1'b1));
    for (int k = 0; k < 5; k++) begin
      cycle(o, e);
      n_vec++; if (o !== e) begin n_bad++; $display("FAIL mid_again cyc=%0d got=%h want=%h", cyc, o, e); end
      if (k == 0) begin
        n_vec++; if (o[B_G0:B_G1] !== 2'b10)
          begin n_bad++; $display("FAIL mid_rr got=%b want=10", o[B_G0:B_G1]); end
      end
    end
  endtask

  task automatic test_random();
    logic [VW-1:0] o, e;
    for (int k = 0; k < 500; k++) begin
      if (k < 440) begin
        if (q0.size() < 4 && $urandom_range(0, 2) == 0) q0.push_back(rnd_acc());
        if (q1.size() < 4 && $urandom_range(0, 2) == 0) q1.push_back(rnd_acc());
        hold0 = ($urandom_range(0, 9) == 0);
        hold1 = ($urandom_range(0, 9) == 0);
      end else begin
        hold0 = 1'b0; hold1 = 1'b0;
      end
      cycle(o, e);
      n_vec++; if (o !== e) begin n_bad++; $display("FAIL random cyc=%0d got=%h want=%h", cyc, o, e); end
    end
  endtask

  initial begin
    logic [DW-1:0] v;
    n_vec = 0; n_bad = 0; cyc = 0;
    own = -1; cnt = 0; rr = 0; exp_rd0 = '0; exp_rd1 = '0;
    hold0 = 1'b0; hold1 = 1'b0;
    m0_req = 1'b0; m0_wen = 1'b0; m0_addr = '0; m0_wdata = '0; m0_last = 1'b0;
    m1_req = 1'b0; m1_wen = 1'b0; m1_addr = '0; m1_wdata = '0; m1_last = 1'b0;
    for (int i = 0; i < 256; i++) begin
      v = {$urandom, $urandom};
      mem[i] = v; shadow[i] = v;
    end
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_single_reads();
    test_contention();
    test_max_burst();
    test_interleave();
    test_write_readback();
    test_reset_midburst();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/sp_bram_arbiter.md
Name: sp_bram_arbiter

Overview:
- Shares one port of the scratchpad (sp) block RAM between two requesters.
- Requester 0 is the multiplier datapath's sp port. Requester 1 is a loader/host port that preloads operands and drains results.
- Sits between the requesters and the DPI/BRAM port. Grants one access per cycle with burst locking and round-robin fairness.
- Routes read data back to the requester that issued each read, using a read-latency tag pipeline.

Parameters:
ADDR_W, 32, address width (byte address, passed through unchanged)
DATA_W, 64, data width
RD_LAT, 1, BRAM read latency in cycles (1..4)
MAX_BURST, 16, maximum consecutive grants to one owner before forced hand-over (power of two, >=2)

Ports:
clk  input  1  clock, all logic rising-edge
rst  input  1  synchronous reset, active-high
m0_req  input  1  requester 0 wants an access this cycle
m0_wen  input  1  requester 0 access is a write
m0_addr  input  ADDR_W  requester 0 address
m0_wdata  input  DATA_W  requester 0 write data
m0_last  input  1  requester 0 final access of its burst
m0_gnt  output  1  requester 0 access issued this cycle (combinational)
m0_rvalid  output  1  read data valid for requester 0
m0_rdata  output  DATA_W  read data for requester 0
m1_req, m1_wen, m1_addr, m1_wdata, m1_last, m1_gnt, m1_rvalid, m1_rdata  same as m0_* for requester 1
bram_addr  output  ADDR_W  BRAM address
bram_wen  output  1  BRAM write enable
bram_wdata  output  DATA_W  BRAM write data
bram_rdata  input  DATA_W  BRAM read data, valid RD_LAT cycles after address

Behaviour:
- State machine: IDLE, OWN0, OWN1. Registers: rr_ptr (1b, next preferred requester), burst_cnt (log2(MAX_BURST) bits), rd_tag shift pipe of RD_LAT entries {valid, id}.
- Reset values: state=IDLE, rr_ptr=0, burst_cnt=0, rd_tag all invalid.
- Reset outputs: m*_gnt=0, m*_rvalid=0, m*_rdata=0, bram_wen=0, bram_addr=0, bram_wdata=0.
- IDLE:
  - Only one req: that requester is granted in the same cycle.
  - Both req: requester rr_ptr is granted.
  - Neither req: bram_wen=0, bram_addr=0, bram_wdata=0.
- On a grant from IDLE:
  - If the granted access has last=1, or MAX_BURST==1 semantics apply, stay IDLE and set rr_ptr to the other requester.
  - Otherwise go to OWNx with burst_cnt=1.
- OWNx, mx_req=1:
  - Granted unconditionally; the other requester is blocked.
  - burst_cnt increments.
  - Release when mx_last=1 or burst_cnt==MAX_BURST-1 (this grant is the MAX_BURST-th): go to IDLE, rr_ptr = other requester.
- OWNx, mx_req=0: no grant this cycle, go to IDLE, rr_ptr = other requester. The dropped request ends the burst.
- Grant cycle muxing: bram_addr/bram_wen/bram_wdata come from the granted requester, combinationally, same cycle.
- gnt is never asserted without req. At most one gnt per cycle.
- Read tracking:
  - A granted access with wen=0 pushes {1, id} into rd_tag. A write or no-grant pushes {0, x}.
  - RD_LAT cycles after the grant edge, m<id>_rvalid=1 for one cycle with m<id>_rdata=bram_rdata.
  - The other requester's rvalid is 0 and its rdata holds its previous value.
- Back-to-back reads, even from alternating owners, return in issue order, one per cycle, with no bubbles.
- Read latency is fixed at RD_LAT. Writes produce no rvalid.
- Hand-over costs zero idle cycles when the other requester is waiting: release cycle grants x, next cycle grants the other via IDLE.
- Reset mid-burst or with reads in flight: all state clears the next cycle. In-flight reads are discarded (no rvalid). Requesters must reissue.
- Address and data are passed through unchanged. No width conversion, no byte masking: a write is a full DATA_W word.

Test Plan:
- Single requester reads: m0 reads addr 0x00,0x08,0x10 with last on 3rd, BRAM preloaded 0xA0,0xA1,0xA2 -> m0_gnt 3 cycles; m0_rvalid 3 consecutive cycles starting RD_LAT later with rdata A0,A1,A2; m1_rvalid never high.
- Contention after reset: both req in the same cycle, bursts of length 2 -> m0 granted first (rr_ptr=0), 2 grants, then m1 2 grants; total 4 consecutive grant cycles, no idle cycle.
- MAX_BURST forced hand-over: m0 requests 20 reads with last never asserted while m1 requests -> m0 receives exactly 16 grants, then m1 is granted; m0 resumes after m1's burst ends.
- Interleaved read return: m0 read 0x40 (data 0x11) then m1 read 0x48 (data 0x22) in consecutive cycles, RD_LAT=2 -> m0_rvalid with 0x11 at t+2, m1_rvalid with 0x22 at t+3.
- Write then read-back: m1 writes 0xDEADBEEF_CAFEF00D to 0x100, then reads 0x100 -> bram_wen=1 in the write cycle only; read returns 0xDEADBEEF_CAFEF00D; no rvalid for the write.
- Reset mid-burst: assert rst while m0 owns and 1 read is in flight -> no m0_rvalid afterwards; state IDLE, rr_ptr=0; next simultaneous request grants m0.
